armleg_run_controller: RTL and testbench

- Sits directly upstream of the ARMLEG core in the simulation top. Takes the global CLOCK/RESET and generates the core's reset (CORE_RESET).
- Holds the core in reset for a fixed number of cycles, releases it, and counts executed cycles until the core signals halt.
- Optionally enforces a watchdog cycle limit, so runaway programs terminate deterministically.

---
 rtl/armleg_run_controller.sv | 124 ++++++++++++
 tb/tb_armleg_run_controller.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/armleg_run_controller.sv
// Run controller for the ARMLEG core: holds CORE_RESET, releases the core, counts RUN cycles until halt.
// Defining ARMLEG_RUN_WATCHDOG_EN adds a watchdog that ends a run after MAX_CYCLES RUN cycles.
module armleg_run_controller #(
  parameter int HOLD_CYCLES = 4,
  parameter int MAX_CYCLES  = 1024,
  parameter int CNT_W       = 16
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             start,
  input  logic             abort,
  input  logic             halt,
  output logic             CORE_RESET,
  output logic             running,
  output logic             done,
  output logic             timed_out,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int               HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_SAT   = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HOLD    = 3'd1,
    S_RUN     = 3'd2,
    S_HALTED  = 3'd3,
    S_TIMEOUT = 3'd4
  } state_t;

  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("HOLD_CYCLES must be at least 1");
  end
  if ((MAX_CYCLES < 1) || (longint'(MAX_CYCLES) > ((longint'(1) << CNT_W) - 1))) begin : g_bad_max
    $error("MAX_CYCLES must lie in 1 .. 2^CNT_W-1");
  end

  state_t            r_state;
  state_t            w_next_state;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [HOLD_W-1:0] w_hold_cnt_next;
  logic [CNT_W-1:0]  r_cycle_cnt;
  logic [CNT_W-1:0]  w_cycle_cnt_next;
  logic [CNT_W-1:0]  w_cycle_inc;
  logic              w_wd_hit;
  logic              r_core_reset;
  logic              r_running;
  logic              r_done;

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  assign w_cycle_inc = (r_cycle_cnt == CNT_SAT) ? r_cycle_cnt : (r_cycle_cnt + CNT_W'(1));

`ifdef ARMLEG_RUN_WATCHDOG_EN
  assign w_wd_hit = (w_cycle_inc == CNT_W'(MAX_CYCLES));
`else
  assign w_wd_hit = 1'b0;
`endif

  always_comb begin
    w_next_state     = r_state;
    w_hold_cnt_next  = r_hold_cnt;
    w_cycle_cnt_next = r_cycle_cnt;
    case (r_state)
      S_IDLE, S_HALTED, S_TIMEOUT: begin
        if (start) begin
          w_next_state     = S_HOLD;
          w_hold_cnt_next  = '0;
          w_cycle_cnt_next = '0;
        end
      end
      S_HOLD: begin
        w_hold_cnt_next = r_hold_cnt + HOLD_W'(1);
        if (abort)                        w_next_state = S_IDLE;
        else if (r_hold_cnt == HOLD_LAST) w_next_state = S_RUN;
      end
      S_RUN: begin
        // The exiting edge is still a RUN cycle, so it is counted too.
        w_cycle_cnt_next = w_cycle_inc;
        if (abort)         w_next_state = S_IDLE;
        else if (halt)     w_next_state = S_HALTED;
        else if (w_wd_hit) w_next_state = S_TIMEOUT;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_state      <= S_IDLE;
      r_hold_cnt   <= '0;
      r_cycle_cnt  <= '0;
      r_core_reset <= 1'b1;
      r_running    <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_hold_cnt   <= w_hold_cnt_next;
      r_cycle_cnt  <= w_cycle_cnt_next;
      r_core_reset <= (w_next_state != S_RUN);
      r_running    <= (w_next_state == S_RUN);
      r_done       <= (w_next_state == S_HALTED) || (w_next_state == S_TIMEOUT);
    end
  end

`ifdef ARMLEG_RUN_WATCHDOG_EN
  logic r_timed_out;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) r_timed_out <= 1'b0;
    else       r_timed_out <= (w_next_state == S_TIMEOUT);
  end

  assign timed_out = r_timed_out;
`else
  assign timed_out = 1'b0;
`endif

  assign CORE_RESET  = r_core_reset;
  assign running     = r_running;
  assign done        = r_done;
  assign cycle_count = r_cycle_cnt;

endmodule

// File: tb/tb_armleg_run_controller.sv
// Bench for armleg_run_controller: vector table, corner-case sequences and randomized runs vs a reference model.
// Works with or without ARMLEG_RUN_WATCHDOG_EN defined.
module tb_armleg_run_controller;

  localparam int HOLD = 4;
  localparam int MAXC = 16;
  localparam int W    = 6;
  localparam int SAT  = (1 << W) - 1;
`ifdef ARMLEG_RUN_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic         CLOCK = 1'b0;
  logic         RESET;
  logic         start;
  logic         abort;
  logic         halt;
  logic         CORE_RESET;
  logic         running;
  logic         done;
  logic         timed_out;
  logic [W-1:0] cycle_count;

  int errors = 0;
  int checks = 0;

  // clock / reset
  always #5 CLOCK = ~CLOCK;

  armleg_run_controller #(
    .HOLD_CYCLES(HOLD),
    .MAX_CYCLES (MAXC),
    .CNT_W      (W)
  ) dut (
    .CLOCK      (CLOCK),
    .RESET      (RESET),
    .start      (start),
    .abort      (abort),
    .halt       (halt),
    .CORE_RESET (CORE_RESET),
    .running    (running),
    .done       (done),
    .timed_out  (timed_out),
    .cycle_count(cycle_count)
  );

  // reference model: hold cycles remaining, running flag, sticky flags, counter
  int m_hold_left;
  bit m_run;
  bit m_done;
  bit m_to;
  int m_cnt;

  function automatic void model_reset();
    m_hold_left = 0;
    m_run       = 1'b0;
    m_done      = 1'b0;
    m_to        = 1'b0;
    m_cnt       = 0;
  endfunction

  function automatic void model_step(input bit s, input bit a, input bit h);
    if (m_run) begin
      m_cnt = (m_cnt < SAT) ? m_cnt + 1 : SAT;
      if (a) m_run = 1'b0;
      else if (h) begin
        m_run  = 1'b0;
        m_done = 1'b1;
      end else if (WD && m_cnt == MAXC) begin
        m_run  = 1'b0;
        m_done = 1'b1;
        m_to   = 1'b1;
      end
    end else if (m_hold_left > 0) begin
      if (a) m_hold_left = 0;
      else begin
        m_hold_left = m_hold_left - 1;
        if (m_hold_left == 0) m_run = 1'b1;
      end
    end else if (s) begin
      m_hold_left = HOLD;
      m_cnt       = 0;
      m_done      = 1'b0;
      m_to        = 1'b0;
    end
  endfunction

  // scoreboard
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input bit cr, input bit run, input bit dn,
                           input bit to, input int cnt);
    check({tag, " core_reset"}, 32'(CORE_RESET), 32'(cr));
    check({tag, " running"}, 32'(running), 32'(run));
    check({tag, " done"}, 32'(done), 32'(dn));
    check({tag, " timed_out"}, 32'(timed_out), 32'(to));
    check({tag, " cycle_count"}, 32'(cycle_count), 32'(cnt));
  endtask

  task automatic check_model(input string tag);
    check_all(tag, !m_run, m_run, m_done, m_to, m_cnt);
  endtask

  // drivers
  task automatic tick(input bit s, input bit a, input bit h);
    start = s;
    abort = a;
    halt  = h;
    model_step(s, a, h);
    @(posedge CLOCK);
    #1;
  endtask

  task automatic do_reset();
    start = 1'b0;
    abort = 1'b0;
    halt  = 1'b0;
    RESET = 1'b1;
    model_reset();
    @(posedge CLOCK);
    @(posedge CLOCK);
    #1;
    RESET = 1'b0;
  endtask

  task automatic start_to_run();
    tick(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < HOLD; i++) tick(1'b0, 1'b0, 1'b0);
  endtask

  // vector table
  typedef struct {
    bit s, a, h;
    bit cr, run, dn, to;
    int cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input bit s, input bit a, input bit h, input bit cr,
                              input bit run, input bit dn, input bit to, input int cnt);
    vec_t v;
    v.s = s; v.a = a; v.h = h;
    v.cr = cr; v.run = run; v.dn = dn; v.to = to; v.cnt = cnt;
    vecs.push_back(v);
  endfunction

  initial begin
    // start pulse, 4 hold cycles, run, halt on the 10th RUN edge
    add(1, 0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0);
    for (int k = 1; k <= 9; k++) add(0, 0, 0, 0, 1, 0, 0, k);
    add(0, 0, 1, 1, 0, 1, 0, 10);
    add(0, 1, 1, 1, 0, 1, 0, 10);
    // restart from HALTED; start pulses during RUN are ignored
    add(1, 0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0, 1);
    add(0, 0, 0, 0, 1, 0, 0, 2);
    add(1, 0, 0, 0, 1, 0, 0, 3);
    // abort beats halt on the same RUN edge; halt/abort inert in IDLE
    add(0, 1, 1, 1, 0, 0, 0, 4);
    add(0, 0, 1, 1, 0, 0, 0, 4);
    add(0, 1, 0, 1, 0, 0, 0, 4);
    // abort during HOLD returns to IDLE for good
    add(1, 0, 0, 1, 0, 0, 0, 0);
    add(0, 1, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 0, 0, 1, 0, 0, 0, 0);

    // reset state
    start = 1'b0;
    abort = 1'b0;
    halt  = 1'b0;
    RESET = 1'b1;
    #3;
    check_all("reset_async", 1, 0, 0, 0, 0);
    do_reset();
    check_all("reset_released", 1, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      tick(vecs[i].s, vecs[i].a, vecs[i].h);
      check_all($sformatf("vec%0d", i), vecs[i].cr, vecs[i].run, vecs[i].dn, vecs[i].to, vecs[i].cnt);
    end

    // watchdog limit at MAX_CYCLES RUN edges
    do_reset();
    start_to_run();
    for (int i = 0; i < MAXC - 1; i++) tick(1'b0, 1'b0, 1'b0);
    check_all("wd_before", 0, 1, 0, 0, MAXC - 1);
    tick(1'b0, 1'b0, 1'b0);
    if (WD) begin
      check_all("wd_hit", 1, 0, 1, 1, MAXC);
      tick(1'b0, 1'b1, 1'b1);
      check_all("wd_sticky", 1, 0, 1, 1, MAXC);
      tick(1'b1, 1'b0, 1'b0);
      check_all("wd_restart", 1, 0, 0, 0, 0);
    end else begin
      check_all("nowd_16", 0, 1, 0, 0, MAXC);
      tick(1'b0, 1'b0, 1'b0);
      check_all("nowd_17", 0, 1, 0, 0, MAXC + 1);
    end

    // halt on the same edge the watchdog would fire
    do_reset();
    start_to_run();
    for (int i = 0; i < MAXC - 1; i++) tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    check_all("halt_vs_wd", 1, 0, 1, 0, MAXC);

    // saturation without a watchdog
    if (!WD) begin
      do_reset();
      start_to_run();
      for (int i = 0; i < SAT + 7; i++) tick(1'b0, 1'b0, 1'b0);
      check_all("saturate", 0, 1, 0, 0, SAT);
      tick(1'b0, 1'b0, 1'b1);
      check_all("saturate_halt", 1, 0, 1, 0, SAT);
    end

    // asynchronous reset between edges mid-RUN
    do_reset();
    start_to_run();
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b0);
    check_all("pre_async", 0, 1, 0, 0, 5);
    #2;
    RESET = 1'b1;
    model_reset();
    #1;
    check_all("async_reset", 1, 0, 0, 0, 0);
    @(posedge CLOCK);
    #1;
    RESET = 1'b0;
    tick(1'b0, 1'b0, 1'b0);
    check_all("after_async", 1, 0, 0, 0, 0);

    // randomized runs against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      tick(($urandom_range(0, 7) == 0), ($urandom_range(0, 39) == 0), ($urandom_range(0, 11) == 0));
      check_model($sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
